ook_wdm_transmitter: RTL and testbench



---
 rtl/ook_wdm_transmitter.sv | 171 +++++++++++++++++
 tb/tb_ook_wdm_transmitter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ook_wdm_transmitter.sv
// rtl/ook_wdm_transmitter.sv - OOK serializer/modulator for a WDM laser comb
//
// Purpose:
//   Accepts one DataWidth-bit word per wavelength channel over a valid/ready
//   handshake, serializes every channel MSB-first at one bit per clock, and
//   on-off-keys the matching channel of an incoming CW laser comb.
//
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_en           transmitter enable (laser gate)
//   i_laser_waves  CW comb; per-channel power plus pass-through fields
//   i_data         per-channel words, element [c] drives channel c
//   i_valid        i_data valid
//   o_ready        word can be accepted this cycle
//   o_phot_waves   modulated optical bundle
//   o_busy         frame in progress
//   o_sym          current symbol per channel

package wdm_pkg;

  // One optical carrier. power holds an IEEE-754 double (watts) so the
  // bundle stays a plain packed type that can cross module ports.
  typedef struct packed {
    logic [63:0] power;
    logic [15:0] lambda_id;
    logic [15:0] phase;
  } wave_t;

  localparam int WAVES8_SIZE = 8;

  typedef wave_t [WAVES8_SIZE-1:0] waves8_t;

endpackage

module ook_wdm_transmitter #(
  parameter type waves_t   = wdm_pkg::waves8_t,
  parameter int  NumCh     = 8,
  parameter int  DataWidth = 8,
  parameter real ExtRatio  = 0.1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_en,
  input  waves_t                               i_laser_waves,
  input  logic [NumCh-1:0][DataWidth-1:0]      i_data,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output waves_t                               o_phot_waves,
  output logic                                 o_busy,
  output logic [NumCh-1:0]                     o_sym
);

  localparam int BundleSize = $bits(waves_t) / $bits(wdm_pkg::wave_t);
  localparam int CntW       = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);

  if (NumCh != BundleSize) begin : g_chk_numch
    $error("ook_wdm_transmitter: NumCh does not match the wave bundle size");
  end
  if (DataWidth < 1) begin : g_chk_width
    $error("ook_wdm_transmitter: DataWidth must be at least 1");
  end
  if ((ExtRatio < 0.0) || (ExtRatio > 1.0)) begin : g_chk_ext
    $error("ook_wdm_transmitter: ExtRatio must lie in [0.0, 1.0]");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [CntW-1:0]                  r_cnt;
  logic [CntW-1:0]                  w_cnt_nxt;
  logic [NumCh-1:0][DataWidth-1:0]  r_shreg;
  logic [NumCh-1:0][DataWidth-1:0]  w_shreg_nxt;

  logic w_last;
  logic w_accept;

  // The last bit of a frame is also the slot where the next word may be
  // taken, which is what makes back-to-back frames gapless.
  assign w_last   = (r_state == SHIFT) && (r_cnt == LastCnt);
  assign o_ready  = i_en && ((r_state == IDLE) || w_last);
  assign w_accept = i_valid && o_ready;
  assign o_busy   = (r_state == SHIFT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    if (!i_en) begin
      // Laser gate dropped: any partial frame is thrown away.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_shreg_nxt = '0;
    end else if (w_accept) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = '0;
      w_shreg_nxt = i_data;
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_shreg_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CntW'(1);
            for (int c = 0; c < NumCh; c++) begin
              w_shreg_nxt[c] = r_shreg[c] << 1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_sym = '0;
    if (r_state == SHIFT) begin
      for (int c = 0; c < NumCh; c++) begin
        o_sym[c] = r_shreg[c][DataWidth-1];
      end
    end
  end

  // Scales one carrier: full power for a '1', ExtRatio for a '0', dark when
  // the gate is off. Works on the raw double bits so the port stays packed.
  function automatic logic [63:0] f_mod_power(
    input logic [63:0] i_pbits,
    input logic        i_sym,
    input logic        i_gate
  );
    real p;
    p = $bitstoreal(i_pbits);
    if (!i_gate) begin
      p = 0.0;
    end else if (!i_sym) begin
      p = p * ExtRatio;
    end
    return $realtobits(p);
  endfunction

  // Purely combinational from the registered symbols and the live comb, so
  // laser power changes and the enable gate take effect in the same cycle.
  always_comb begin
    o_phot_waves = i_laser_waves;
    for (int c = 0; c < NumCh; c++) begin
      o_phot_waves[c].power = f_mod_power(i_laser_waves[c].power, o_sym[c], i_en);
    end
  end

endmodule

// File: tb/tb_ook_wdm_transmitter.sv
// tb/tb_ook_wdm_transmitter.sv - scoreboard bench for ook_wdm_transmitter
module tb_ook_wdm_transmitter;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  wdm_pkg::waves8_t      laser;
  logic [7:0][7:0]       data;
  logic                  valid;
  logic                  ready;
  wdm_pkg::waves8_t      phot;
  logic                  busy;
  logic [7:0]            sym;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic       ready;
    logic       busy;
    logic [7:0] sym;
    int         pw0;   // expected ch0 power, milli-units of 1.0
    int         pwo;   // expected power on channels 1..7
  } exp_t;

  exp_t sb[$];

  ook_wdm_transmitter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_laser_waves (laser),
    .i_data        (data),
    .i_valid       (valid),
    .o_ready       (ready),
    .o_phot_waves  (phot),
    .o_busy        (busy),
    .o_sym         (sym)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: photodetector model with responsivity 1.0 sums channel powers.
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    int   pm;
    int   cur;
    int   pexp;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      bad = 0;
      cur = 0;
      n_vec++;
      if (ready !== e.ready) begin
        $display("FAIL %s ready act=%0b exp=%0b", e.tag, ready, e.ready);
        bad = 1;
      end
      if (busy !== e.busy) begin
        $display("FAIL %s busy act=%0b exp=%0b", e.tag, busy, e.busy);
        bad = 1;
      end
      if (sym !== e.sym) begin
        $display("FAIL %s sym act=%02h exp=%02h", e.tag, sym, e.sym);
        bad = 1;
      end
      for (int c = 0; c < 8; c++) begin
        pm   = int'($bitstoreal(phot[c].power) * 1000.0);
        pexp = (c == 0) ? e.pw0 : e.pwo;
        cur += pm;
        if (pm != pexp) begin
          $display("FAIL %s power ch%0d act=%0d exp=%0d (milli)", e.tag, c, pm, pexp);
          bad = 1;
        end
        if ((phot[c].lambda_id !== 16'(1550 + c)) || (phot[c].phase !== 16'(3 * c))) begin
          $display("FAIL %s fields ch%0d act=%0d/%0d exp=%0d/%0d", e.tag, c,
                   phot[c].lambda_id, phot[c].phase, 1550 + c, 3 * c);
          bad = 1;
        end
      end
      if (cur != e.pw0 + 7 * e.pwo) begin
        $display("FAIL %s photocurrent act=%0d exp=%0d (milli)", e.tag, cur, e.pw0 + 7 * e.pwo);
        bad = 1;
      end
      if (bad) n_err++;
    end
  end

  task automatic step(input string tag, input logic rdy, input logic bsy,
                      input logic [7:0] s, input int pw0, input int pwo);
    exp_t e;
    e.tag   = tag;
    e.ready = rdy;
    e.busy  = bsy;
    e.sym   = s;
    e.pw0   = pw0;
    e.pwo   = pwo;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] w);
    for (int c = 0; c < 8; c++) data[c] = w;
  endtask

  task automatic set_ch0_laser(input real p);
    laser[0].power = $realtobits(p);
  endtask

  initial begin
    logic [7:0] w;
    logic       b;
    rst_n = 1'b0;
    en    = 1'b1;
    valid = 1'b0;
    data  = '0;
    for (int c = 0; c < 8; c++) begin
      laser[c].power     = $realtobits(1.0);
      laser[c].lambda_id = 16'(1550 + c);
      laser[c].phase     = 16'(3 * c);
    end
    @(posedge clk);
    #1;
    step("rst", 1'b1, 1'b0, 8'h00, 100, 100);
    rst_n = 1'b1;
    step("rst_rel", 1'b1, 1'b0, 8'h00, 100, 100);

    // single word on ch0 only
    w       = 8'hA5;
    data[0] = w;
    valid   = 1'b1;
    step("t2_acc", 1'b1, 1'b0, 8'h00, 100, 100);
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b = w[7-k];
      step("t2_bit", (k == 7), 1'b1, {7'b0, b}, b ? 1000 : 100, 100);
    end
    step("t2_idle", 1'b1, 1'b0, 8'h00, 100, 100);

    // back-to-back FF then 00
    set_all(8'hFF);
    valid = 1'b1;
    step("t3_acc", 1'b1, 1'b0, 8'h00, 100, 100);
    set_all(8'h00);
    for (int k = 0; k < 8; k++) step("t3_f1", (k == 7), 1'b1, 8'hFF, 1000, 1000);
    valid = 1'b0;
    for (int k = 0; k < 8; k++) step("t3_f2", (k == 7), 1'b1, 8'h00, 100, 100);
    step("t3_idle", 1'b1, 1'b0, 8'h00, 100, 100);

    // enable dropped during bit 3
    set_all(8'hF0);
    valid = 1'b1;
    step("t4_acc", 1'b1, 1'b0, 8'h00, 100, 100);
    valid = 1'b0;
    for (int k = 0; k < 3; k++) step("t4_bit", 1'b0, 1'b1, 8'hFF, 1000, 1000);
    en = 1'b0;
    step("t4_drop", 1'b0, 1'b1, 8'hFF, 0, 0);
    step("t4_off", 1'b0, 1'b0, 8'h00, 0, 0);
    en = 1'b1;
    step("t4_reen", 1'b1, 1'b0, 8'h00, 100, 100);
    step("t4_reen2", 1'b1, 1'b0, 8'h00, 100, 100);

    // valid raised mid-frame waits for the last bit
    w = 8'h81;
    set_all(w);
    valid = 1'b1;
    step("t5_acc", 1'b1, 1'b0, 8'h00, 100, 100);
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        set_all(8'h3C);
        valid = 1'b1;
      end
      b = w[7-k];
      step("t5_f1", (k == 7), 1'b1, {8{b}}, b ? 1000 : 100, b ? 1000 : 100);
    end
    valid = 1'b0;
    w = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      b = w[7-k];
      step("t5_f2", (k == 7), 1'b1, {8{b}}, b ? 1000 : 100, b ? 1000 : 100);
    end
    step("t5_idle", 1'b1, 1'b0, 8'h00, 100, 100);

    // loopback current, with a laser power change mid-frame
    set_all(8'hFF);
    valid = 1'b1;
    step("t6_acc", 1'b1, 1'b0, 8'h00, 100, 100);
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        set_ch0_laser(0.5);
        step("t6_laser", 1'b0, 1'b1, 8'hFF, 500, 1000);
        set_ch0_laser(1.0);
      end else begin
        step("t6_bit", (k == 7), 1'b1, 8'hFF, 1000, 1000);
      end
    end
    step("t6_idle", 1'b1, 1'b0, 8'h00, 100, 100);

    // reset asserted mid-frame
    set_all(8'hFF);
    valid = 1'b1;
    step("t7_acc", 1'b1, 1'b0, 8'h00, 100, 100);
    valid = 1'b0;
    step("t7_bit", 1'b0, 1'b1, 8'hFF, 1000, 1000);
    step("t7_bit", 1'b0, 1'b1, 8'hFF, 1000, 1000);
    rst_n = 1'b0;
    step("t7_rst", 1'b1, 1'b0, 8'h00, 100, 100);
    rst_n = 1'b1;
    step("t7_idle", 1'b1, 1'b0, 8'h00, 100, 100);
    step("t7_idle2", 1'b1, 1'b0, 8'h00, 100, 100);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain pending act=%0d exp=0", sb.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
